// File: rtl/mbldcm_pkg.sv
// Shared constants and types for the BLDC half-bridge leg controller:
// commutation step encoding, FSM state encoding and the legal leg offsets.
package mbldcm_pkg;

    localparam logic [2:0] PHASE_0   = 3'd0;
    localparam logic [2:0] PHASE_1   = 3'd1;
    localparam logic [2:0] PHASE_2   = 3'd2;
    localparam logic [2:0] PHASE_3   = 3'd3;
    localparam logic [2:0] PHASE_4   = 3'd4;
    localparam logic [2:0] PHASE_5   = 3'd5;
    localparam logic [2:0] NUM_STEPS = 3'd6;

    // The three legs of a motor are spaced two commutation steps apart.
    localparam logic [2:0] LEG_PHASE_DIFF [3] = '{3'd0, 3'd2, 3'd4};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HIGH   = 3'd1,
        ST_LOW    = 3'd2,
        ST_DEAD_H = 3'd3,
        ST_DEAD_L = 3'd4
    } state_e;

    // Modulo-6 addition for step offsets; base is a legal step and step <= 5.
    function automatic logic [2:0] phase_add(input logic [2:0] base, input logic [2:0] step);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= {1'b0, NUM_STEPS}) begin
            sum = sum - {1'b0, NUM_STEPS};
        end
        return sum[2:0];
    endfunction

endpackage

// File: rtl/mbldcm_commutation_decoder.sv
// Combinational decode of the 6-step commutation phase and PWM inputs into
// high/low switch requests for one leg, plus an illegal-phase flag.
module mbldcm_commutation_decoder
    import mbldcm_pkg::*;
#(
    parameter logic [2:0] pPhaseDiff = 3'd0
) (
    input  logic [2:0] phase_i,
    input  logic       high_pwm_i,
    input  logic       low_pwm_i,
    output logic       req_high_o,
    output logic       req_low_o,
    output logic       illegal_o
);

    // Steps d and d+1 drive this leg with PWM; d+3 and d+4 hold it low.
    localparam logic [2:0] DRIVE_A = phase_add(pPhaseDiff, 3'd0);
    localparam logic [2:0] DRIVE_B = phase_add(pPhaseDiff, 3'd1);
    localparam logic [2:0] SINK_A  = phase_add(pPhaseDiff, 3'd3);
    localparam logic [2:0] SINK_B  = phase_add(pPhaseDiff, 3'd4);

    always_comb begin
        req_high_o = 1'b0;
        req_low_o  = 1'b0;
        illegal_o  = (phase_i >= NUM_STEPS);
        if ((phase_i == DRIVE_A) || (phase_i == DRIVE_B)) begin
            req_high_o = high_pwm_i;
            req_low_o  = low_pwm_i;
        end else if ((phase_i == SINK_A) || (phase_i == SINK_B)) begin
            req_low_o = 1'b1;
        end
    end

endmodule

// File: rtl/mbldcm_half_bridge_deadtime_controller.sv
// Half-bridge gate controller for one BLDC leg: registered gate FSM with a
// programmable dead time between opposite-side turn-ons and a sticky fault.
module mbldcm_half_bridge_deadtime_controller
    import mbldcm_pkg::*;
#(
    parameter logic [2:0] pPhaseDiff     = 3'd0,
    parameter int         pDeadTimeWidth = 8
) (
    input  logic                      iClk,
    input  logic                      iRst_n,
    input  logic                      iEnable,
    input  logic [2:0]                iPhase,
    input  logic                      iHighPwm,
    input  logic                      iLowPwm,
    input  logic [pDeadTimeWidth-1:0] iDeadTime,
    input  logic                      iClearFault,
    output logic                      oHighSide,
    output logic                      oLowSide,
    output logic                      oDeadActive,
    output logic                      oFault
);

    state_e                    state_q, state_d;
    logic [pDeadTimeWidth-1:0] cnt_q, cnt_d;
    logic                      fault_q, fault_d;
    logic                      req_high, req_low, phase_illegal;
    logic                      fault_set;

    mbldcm_commutation_decoder #(
        .pPhaseDiff (pPhaseDiff)
    ) u_decoder (
        .phase_i    (iPhase),
        .high_pwm_i (iHighPwm),
        .low_pwm_i  (iLowPwm),
        .req_high_o (req_high),
        .req_low_o  (req_low),
        .illegal_o  (phase_illegal)
    );

    assign fault_set = iEnable && (phase_illegal || (req_high && req_low));

    // A new fault beats a simultaneous clear request.
    always_comb begin
        fault_d = fault_q;
        if (fault_set) begin
            fault_d = 1'b1;
        end else if (iClearFault) begin
            fault_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!iEnable || fault_set || fault_q) begin
            // Abrupt shut-off: no dead time is counted on the way to IDLE.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_high && !req_low) begin
                        state_d = ST_HIGH;
                    end else if (req_low && !req_high) begin
                        state_d = ST_LOW;
                    end
                end
                ST_HIGH: begin
                    if (!req_high) begin
                        state_d = ST_DEAD_H;
                        cnt_d   = iDeadTime;
                    end
                end
                ST_LOW: begin
                    if (!req_low) begin
                        state_d = ST_DEAD_L;
                        cnt_d   = iDeadTime;
                    end
                end
                ST_DEAD_H: begin
                    if (req_high) begin
                        state_d = ST_HIGH;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - pDeadTimeWidth'(1);
                    end else if (req_low) begin
                        state_d = ST_LOW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DEAD_L: begin
                    if (req_low) begin
                        state_d = ST_LOW;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - pDeadTimeWidth'(1);
                    end else if (req_high) begin
                        state_d = ST_HIGH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign oHighSide   = (state_q == ST_HIGH);
    assign oLowSide    = (state_q == ST_LOW);
    assign oDeadActive = ((state_q == ST_DEAD_H) || (state_q == ST_DEAD_L)) && (cnt_q != '0);
    assign oFault      = fault_q;

endmodule

// File: tb/tb_mbldcm_half_bridge_deadtime_controller.sv
// Scenario bench for one half-bridge leg (offset 0): stimulus rows push the
// expected {high, low, dead, fault} outputs, popped after the next clock edge.
module tb_mbldcm_half_bridge_deadtime_controller;

    logic       iClk = 1'b0;
    logic       iRst_n;
    logic       iEnable;
    logic [2:0] iPhase;
    logic       iHighPwm;
    logic       iLowPwm;
    logic [7:0] iDeadTime;
    logic       iClearFault;
    logic       oHighSide;
    logic       oLowSide;
    logic       oDeadActive;
    logic       oFault;

    always #5 iClk = ~iClk;

    mbldcm_half_bridge_deadtime_controller #(
        .pPhaseDiff     (3'd0),
        .pDeadTimeWidth (8)
    ) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iEnable     (iEnable),
        .iPhase      (iPhase),
        .iHighPwm    (iHighPwm),
        .iLowPwm     (iLowPwm),
        .iDeadTime   (iDeadTime),
        .iClearFault (iClearFault),
        .oHighSide   (oHighSide),
        .oLowSide    (oLowSide),
        .oDeadActive (oDeadActive),
        .oFault      (oFault)
    );

    typedef struct packed {
        logic       en;
        logic [2:0] ph;
        logic       hp;
        logic       lp;
        logic [7:0] dt;
        logic       clr;
        logic [3:0] exp;
    } row_t;

    logic [3:0] sb[$];
    int n_pass  = 0;
    int n_total = 0;

    function automatic row_t mk(input int en, input int ph, input int hp, input int lp,
                                input int dt, input int clr, input logic [3:0] exp);
        row_t r;
        r.en  = en[0];
        r.ph  = ph[2:0];
        r.hp  = hp[0];
        r.lp  = lp[0];
        r.dt  = dt[7:0];
        r.clr = clr[0];
        r.exp = exp;
        return r;
    endfunction

    // Drive one cycle of stimulus and record what the outputs must be after the edge.
    task automatic apply(input row_t r);
        iEnable     = r.en;
        iPhase      = r.ph;
        iHighPwm    = r.hp;
        iLowPwm     = r.lp;
        iDeadTime   = r.dt;
        iClearFault = r.clr;
        sb.push_back(r.exp);
    endtask

    task automatic test_reset();
        row_t rows[$];
        logic [3:0] obs, exp;
        iRst_n = 1'b0;
        rows.push_back(mk(1, 0, 1, 0, 3, 0, 4'b0000));
        rows.push_back(mk(1, 6, 1, 1, 3, 0, 4'b0000));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge iClk); #1;
            exp = sb.pop_front();
            obs = {oHighSide, oLowSide, oDeadActive, oFault};
            n_total++;
            if (obs !== exp) $display("FAIL reset[%0d] got HLDF=%b want %b", i, obs, exp);
            else begin n_pass++; $display("ok reset[%0d] HLDF=%b", i, obs); end
        end
        iRst_n = 1'b1;
    endtask

    task automatic test_basic_high();
        row_t rows[$];
        logic [3:0] obs, exp;
        rows.push_back(mk(1, 0, 1, 0, 3, 0, 4'b1000));
        rows.push_back(mk(1, 0, 1, 0, 3, 0, 4'b1000));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge iClk); #1;
            exp = sb.pop_front();
            obs = {oHighSide, oLowSide, oDeadActive, oFault};
            n_total++;
            if (obs !== exp) $display("FAIL basic_high[%0d] got HLDF=%b want %b", i, obs, exp);
            else begin n_pass++; $display("ok basic_high[%0d] HLDF=%b", i, obs); end
        end
    endtask

    task automatic test_high_to_low();
        row_t rows[$];
        logic [3:0] obs, exp;
        rows.push_back(mk(1, 0, 0, 1, 3, 0, 4'b0010));
        // Dead time is latched at the load; the later change to 200 must not matter.
        rows.push_back(mk(1, 0, 0, 1, 200, 0, 4'b0010));
        rows.push_back(mk(1, 0, 0, 1, 200, 0, 4'b0010));
        rows.push_back(mk(1, 0, 0, 1, 200, 0, 4'b0000));
        rows.push_back(mk(1, 0, 0, 1, 200, 0, 4'b0100));
        rows.push_back(mk(1, 0, 0, 1, 200, 0, 4'b0100));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge iClk); #1;
            exp = sb.pop_front();
            obs = {oHighSide, oLowSide, oDeadActive, oFault};
            n_total++;
            if (obs !== exp) $display("FAIL high_to_low[%0d] got HLDF=%b want %b", i, obs, exp);
            else begin n_pass++; $display("ok high_to_low[%0d] HLDF=%b", i, obs); end
        end
    endtask

    task automatic test_same_side();
        row_t rows[$];
        logic [3:0] obs, exp;
        rows.push_back(mk(0, 0, 0, 0, 10, 0, 4'b0000));
        rows.push_back(mk(1, 0, 1, 0, 10, 0, 4'b1000));
        rows.push_back(mk(1, 0, 0, 0, 10, 0, 4'b0010));
        rows.push_back(mk(1, 0, 1, 0, 10, 0, 4'b1000));
        // Step 3 sinks this leg; high PWM must be ignored there.
        rows.push_back(mk(1, 3, 1, 0, 10, 0, 4'b0010));
        for (int k = 0; k < 9; k++) rows.push_back(mk(1, 3, 1, 0, 10, 0, 4'b0010));
        rows.push_back(mk(1, 3, 1, 0, 10, 0, 4'b0000));
        rows.push_back(mk(1, 3, 1, 0, 10, 0, 4'b0100));
        rows.push_back(mk(1, 4, 0, 0, 10, 0, 4'b0100));
        rows.push_back(mk(1, 2, 1, 1, 10, 0, 4'b0010));
        rows.push_back(mk(0, 2, 0, 0, 10, 0, 4'b0000));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge iClk); #1;
            exp = sb.pop_front();
            obs = {oHighSide, oLowSide, oDeadActive, oFault};
            n_total++;
            if (obs !== exp) $display("FAIL same_side[%0d] got HLDF=%b want %b", i, obs, exp);
            else begin n_pass++; $display("ok same_side[%0d] HLDF=%b", i, obs); end
        end
    endtask

    task automatic test_illegal_phase();
        row_t rows[$];
        logic [3:0] obs, exp;
        rows.push_back(mk(1, 6, 0, 0, 3, 0, 4'b0001));
        rows.push_back(mk(1, 0, 1, 0, 3, 0, 4'b0001));
        rows.push_back(mk(1, 0, 1, 0, 3, 1, 4'b0000));
        rows.push_back(mk(1, 0, 1, 0, 3, 0, 4'b1000));
        rows.push_back(mk(1, 7, 1, 0, 3, 0, 4'b0001));
        rows.push_back(mk(1, 0, 0, 0, 3, 1, 4'b0000));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge iClk); #1;
            exp = sb.pop_front();
            obs = {oHighSide, oLowSide, oDeadActive, oFault};
            n_total++;
            if (obs !== exp) $display("FAIL illegal_phase[%0d] got HLDF=%b want %b", i, obs, exp);
            else begin n_pass++; $display("ok illegal_phase[%0d] HLDF=%b", i, obs); end
        end
    endtask

    task automatic test_both_request();
        row_t rows[$];
        logic [3:0] obs, exp;
        rows.push_back(mk(1, 0, 1, 1, 3, 0, 4'b0001));
        rows.push_back(mk(1, 0, 1, 1, 3, 1, 4'b0001));
        rows.push_back(mk(1, 0, 0, 0, 3, 1, 4'b0000));
        rows.push_back(mk(1, 0, 1, 0, 3, 0, 4'b1000));
        rows.push_back(mk(1, 0, 1, 1, 3, 0, 4'b0001));
        // While disabled no fault is evaluated, so the clear takes effect.
        rows.push_back(mk(0, 6, 1, 1, 3, 1, 4'b0000));
        rows.push_back(mk(0, 6, 1, 1, 3, 0, 4'b0000));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge iClk); #1;
            exp = sb.pop_front();
            obs = {oHighSide, oLowSide, oDeadActive, oFault};
            n_total++;
            if (obs !== exp) $display("FAIL both_request[%0d] got HLDF=%b want %b", i, obs, exp);
            else begin n_pass++; $display("ok both_request[%0d] HLDF=%b", i, obs); end
        end
    endtask

    task automatic test_disable_reset();
        row_t rows[$];
        logic [3:0] obs, exp;
        rows.push_back(mk(1, 0, 1, 0, 3, 0, 4'b1000));
        rows.push_back(mk(0, 0, 1, 0, 3, 0, 4'b0000));
        rows.push_back(mk(1, 3, 0, 0, 3, 0, 4'b0100));
        rows.push_back(mk(1, 3, 0, 0, 3, 0, 4'b0100));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge iClk); #1;
            exp = sb.pop_front();
            obs = {oHighSide, oLowSide, oDeadActive, oFault};
            n_total++;
            if (obs !== exp) $display("FAIL disable[%0d] got HLDF=%b want %b", i, obs, exp);
            else begin n_pass++; $display("ok disable[%0d] HLDF=%b", i, obs); end
        end
        // Assert reset between edges while in LOW; outputs must drop at once.
        #2;
        iRst_n = 1'b0;
        sb.push_back(4'b0000);
        #1;
        exp = sb.pop_front();
        obs = {oHighSide, oLowSide, oDeadActive, oFault};
        n_total++;
        if (obs !== exp) $display("FAIL async_reset got HLDF=%b want %b", obs, exp);
        else begin n_pass++; $display("ok async_reset HLDF=%b", obs); end
        sb.push_back(4'b0000);
        @(posedge iClk); #1;
        exp = sb.pop_front();
        obs = {oHighSide, oLowSide, oDeadActive, oFault};
        n_total++;
        if (obs !== exp) $display("FAIL reset_hold got HLDF=%b want %b", obs, exp);
        else begin n_pass++; $display("ok reset_hold HLDF=%b", obs); end
        iRst_n = 1'b1;
        apply(mk(1, 3, 0, 0, 3, 0, 4'b0100));
        @(posedge iClk); #1;
        exp = sb.pop_front();
        obs = {oHighSide, oLowSide, oDeadActive, oFault};
        n_total++;
        if (obs !== exp) $display("FAIL after_reset got HLDF=%b want %b", obs, exp);
        else begin n_pass++; $display("ok after_reset HLDF=%b", obs); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        iRst_n      = 1'b0;
        iEnable     = 1'b0;
        iPhase      = 3'd0;
        iHighPwm    = 1'b0;
        iLowPwm     = 1'b0;
        iDeadTime   = 8'd0;
        iClearFault = 1'b0;
        #1;
        test_reset();
        test_basic_high();
        test_high_to_low();
        test_same_side();
        test_illegal_phase();
        test_both_request();
        test_disable_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mbldcm_half_bridge_deadtime_controller.md
Name: mbldcm_half_bridge_deadtime_controller

Overview:
Registered half-bridge gate controller for one BLDC motor leg. It decodes the 6-step commutation phase and the PWM inputs into high-side and low-side requests. It then enforces a programmable dead time before either switch turns on after the opposite switch, and latches a fault on illegal inputs. Three instances, with pPhaseDiff 0, 2 and 4, sit between the commutation sequencer/PWM generator and the gate-driver pins.

Parameters:
pPhaseDiff, 3'd0, phase offset of this leg; legal values 0, 2, 4.
pDeadTimeWidth, 8, width of the dead-time counter and the iDeadTime input.

Ports:
iClk  input  1  clock.
iRst_n  input  1  asynchronous active-low reset.
iEnable  input  1  leg enable; low forces both switches off.
iPhase  input  3  commutation step, 0..5 legal.
iHighPwm  input  1  high-side PWM.
iLowPwm  input  1  low-side PWM (synchronous-rectification complement).
iDeadTime  input  pDeadTimeWidth  dead-time setting, in cycles.
iClearFault  input  1  clears the sticky fault.
oHighSide  output  1  high gate drive, registered.
oLowSide  output  1  low gate drive, registered.
oDeadActive  output  1  high while a dead-time countdown is running.
oFault  output  1  sticky fault flag.

Behaviour:
- Clock and reset: one clock, iClk. Reset iRst_n is asynchronous and active-low. On reset all outputs are 0, the state is IDLE and the counter is 0, taking effect immediately even mid-pulse.
- Request decode (combinational), with d = pPhaseDiff:
  - reqH = iHighPwm when iPhase is d or (d+1) mod 6; otherwise 0.
  - reqL = iLowPwm when iPhase is d or (d+1) mod 6; 1 when iPhase is (d+3) mod 6 or (d+4) mod 6; otherwise 0.
- FSM states: IDLE, HIGH, LOW, DEAD_H, DEAD_L. Outputs are decoded from the registered state: oHighSide = (state==HIGH), oLowSide = (state==LOW), oDeadActive = DEAD_x with cnt != 0.
- Latency from a request to the output: 1 cycle.
- IDLE:
  - reqH only -> HIGH.
  - reqL only -> LOW.
  - none -> stay in IDLE.
- HIGH:
  - stays while reqH.
  - otherwise -> DEAD_H, with cnt loaded from iDeadTime.
- LOW: mirror of HIGH, going to DEAD_L.
- DEAD_H:
  - reqH -> HIGH immediately; same-side re-entry needs no dead time.
  - else if cnt != 0 -> decrement cnt and stay.
  - else reqL -> LOW.
  - else -> IDLE.
- DEAD_L: mirror of DEAD_H.
- Dead-time guarantee: the minimum both-off interval between opposite-side on periods is iDeadTime+1 cycles.
  - iDeadTime is sampled only at the load.
  - Changes to iDeadTime during a countdown are ignored.
- Fault set conditions (evaluated while iEnable=1):
  - iPhase is 6 or 7, or
  - reqH and reqL in the same cycle.
- Fault response: oFault=1 from the next edge. The state goes to IDLE and both outputs are 0 from that edge. While oFault=1 the FSM is held in IDLE.
- Fault clear: iClearFault clears oFault. If a fault condition and iClearFault occur in the same cycle, the set wins.
- iEnable=0: the state goes to IDLE at the next edge and both outputs are 0. No dead time is counted. No faults are evaluated.
- Re-enable starts from IDLE. Because this can follow an abrupt disable, the system must keep iEnable low for at least iDeadTime+1 cycles; this is documented as a system rule.

Decomposition:
- Shared package mbldcm_pkg holds:
  - the phase constants (0..5, and the number of steps, 6),
  - the state encoding enum/localparams,
  - the legal pPhaseDiff values.
- Sub-module mbldcm_commutation_decoder holds the combinational iPhase/PWM -> reqH/reqL/illegal-phase logic, parametrised by pPhaseDiff. The controller owns the FSM, the counter and the fault logic.

Test Plan:
- Basic high drive: pPhaseDiff=0, iDeadTime=3, iPhase=0, iHighPwm=1 -> oHighSide=1 one cycle later, oLowSide=0.
- High-to-low dead time:
  - Stimulus: from HIGH, set iHighPwm=0 and iLowPwm=1 in cycle t.
  - Required: both outputs 0 and oDeadActive=1 from edge t+1.
  - Required: oLowSide=1 at edge t+5, i.e. 4 both-off cycles.
- Same-side resume and low-side drive:
  - Stimulus: iPhase=0, iDeadTime=10, iHighPwm pattern 1,0,1.
  - Required: oHighSide follows 1,0,1 with 1-cycle latency and no extra gap.
  - Then iPhase=3 -> oLowSide=1 after 11 both-off cycles.
- Illegal phase:
  - Stimulus: iPhase=6 while enabled.
  - Required: oFault=1 next cycle and both outputs 0; the fault persists after iPhase returns to 0.
  - Required: iClearFault=1 clears it, and the next request drives normally.
- Both-request fault: iPhase=0 with iHighPwm=iLowPwm=1 -> oFault=1 and no gate asserted. iClearFault asserted while the condition persists -> oFault stays 1.
- Disable and reset:
  - Stimulus: drop iEnable in HIGH -> both outputs 0 next edge, state IDLE.
  - Stimulus: assert iRst_n=0 mid-LOW, between clock edges.
  - Required: oLowSide drops without waiting for a clock edge, and all outputs read 0.
